// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: start flag, zero-stuffed data and CRC-16/X.25 FCS, end flag,
// plus idle-ones and abort-pattern generation with completion/abort status.
module hdlc_tx_framer #(
    parameter int unsigned FCS_EN    = 1,
    parameter int unsigned MAX_BYTES = 126
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Enable,
    input  logic       Tx_AbortFrame,
    input  logic [7:0] Tx_FrameSize,
    input  logic [7:0] Tx_DataOutBuff,
    output logic       Tx_RdBuff,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StFcs   = 3'd3;
    localparam logic [2:0] StEnd   = 3'd4;
    localparam logic [2:0] StAbort = 3'd5;

    localparam logic [7:0]  Flag    = 8'h7E;
    localparam logic [15:0] CrcPoly = 16'h8408;

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  size_q, size_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] crc_q, crc_d;
    logic [2:0]  ones_q, ones_d;
    logic        rd_q;
    logic        tx_q, tx_d;
    logic        valid_q, valid_d;
    logic        aborted_q, aborted_d;

    logic rd, done, stuff, cur_bit, fcs_bit, last_byte, size_ok, abort_req, in_frame;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        byte_d    = byte_q;
        size_d    = size_q;
        hold_d    = hold_q;
        shift_d   = shift_q;
        crc_d     = crc_q;
        ones_d    = ones_q;
        aborted_d = aborted_q;
        tx_d      = 1'b1;
        valid_d   = 1'b0;
        rd        = 1'b0;
        done      = 1'b0;

        size_ok   = (Tx_FrameSize != 8'd0) && ({24'd0, Tx_FrameSize} <= MAX_BYTES);
        stuff     = (ones_q == 3'd5);
        // Bit 0 of a byte comes straight from the holding register as it is loaded.
        cur_bit   = (cnt_q == 4'd0) ? hold_q[0] : shift_q[cnt_q[2:0]];
        fcs_bit   = ~crc_q[cnt_q];
        last_byte = (byte_q == size_q - 8'd1);
        in_frame  = (state_q == StStart) || (state_q == StData) ||
                    (state_q == StFcs) || (state_q == StEnd);
        abort_req = Tx_AbortFrame && in_frame;

        if (rd_q) begin
            hold_d = Tx_DataOutBuff;
        end

        case (state_q)
            StIdle: begin
                if (Tx_Enable && size_ok) begin
                    state_d   = StStart;
                    size_d    = Tx_FrameSize;
                    cnt_d     = 4'd0;
                    aborted_d = 1'b0;
                end
            end
            StStart: begin
                tx_d    = Flag[cnt_q[2:0]];
                valid_d = 1'b1;
                ones_d  = 3'd0;
                crc_d   = 16'hFFFF;
                byte_d  = 8'd0;
                rd      = (cnt_q == 4'd0);
                if (cnt_q == 4'd7) begin
                    state_d = StData;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StData: begin
                valid_d = 1'b1;
                if (stuff) begin
                    tx_d   = 1'b0;
                    ones_d = 3'd0;
                end else begin
                    tx_d   = cur_bit;
                    ones_d = cur_bit ? ones_q + 3'd1 : 3'd0;
                    crc_d  = (crc_q >> 1) ^ ((crc_q[0] ^ cur_bit) ? CrcPoly : 16'h0000);
                    if (cnt_q == 4'd0) begin
                        shift_d = hold_q;
                        rd      = !last_byte;
                        done    = last_byte;
                    end
                    if (cnt_q == 4'd7) begin
                        cnt_d = 4'd0;
                        if (last_byte) begin
                            state_d = (FCS_EN != 0) ? StFcs : StEnd;
                        end else begin
                            byte_d = byte_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StFcs: begin
                valid_d = 1'b1;
                if (stuff) begin
                    tx_d   = 1'b0;
                    ones_d = 3'd0;
                end else begin
                    tx_d   = fcs_bit;
                    ones_d = fcs_bit ? ones_q + 3'd1 : 3'd0;
                    if (cnt_q == 4'd15) begin
                        state_d = StEnd;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StEnd: begin
                // A run of five ones at the end of the payload still needs its stuffed zero.
                valid_d = 1'b1;
                ones_d  = 3'd0;
                if (stuff) begin
                    tx_d = 1'b0;
                end else begin
                    tx_d = Flag[cnt_q[2:0]];
                    if (cnt_q == 4'd7) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StAbort: begin
                tx_d = (cnt_q != 4'd0);
                if (cnt_q == 4'd7) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase

        if (abort_req) begin
            state_d   = StAbort;
            cnt_d     = 4'd0;
            aborted_d = 1'b1;
            rd        = 1'b0;
            done      = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            byte_q    <= 8'd0;
            size_q    <= 8'd0;
            hold_q    <= 8'd0;
            shift_q   <= 8'd0;
            crc_q     <= 16'hFFFF;
            ones_q    <= 3'd0;
            rd_q      <= 1'b0;
            tx_q      <= 1'b1;
            valid_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            byte_q    <= byte_d;
            size_q    <= size_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            ones_q    <= ones_d;
            rd_q      <= rd;
            tx_q      <= tx_d;
            valid_q   <= valid_d;
            aborted_q <= aborted_d;
        end
    end

    assign Tx              = tx_q;
    assign Tx_ValidFrame   = valid_q;
    assign Tx_RdBuff       = rd;
    assign Tx_Done         = done;
    assign Tx_AbortedTrans = aborted_q;

endmodule
